// File: rtl/relay_pulse_controller_pkg.sv
// Shared relay-driver types: channel count and sequencer states.
// Also imported by the management register interface.
package relay_pulse_controller_pkg;

  localparam int RELAY_COUNT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEAD,
    ST_PULSE,
    ST_SETTLE,
    ST_DONE
  } relay_state_t;

  function automatic int max3(int a, int b, int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/relay_pulse_controller.sv
// Latching-relay coil sequencer: dead time, one coil pulse, settle time.
// Every output is registered; only one coil can be on at a time.
module relay_pulse_controller
  import relay_pulse_controller_pkg::*;
#(
  parameter int NUM_RELAYS    = RELAY_COUNT,
  parameter int DEAD_CYCLES   = 1875,
  parameter int PULSE_CYCLES  = 1875000,
  parameter int SETTLE_CYCLES = 937500,
  localparam int CH_W = (NUM_RELAYS > 1) ? $clog2(NUM_RELAYS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  relay_en,
  input  logic                  relay_dir,
  input  logic [CH_W-1:0]       relay_channel,
  output logic                  relay_done,
  output logic                  relay_busy,
  output logic                  cmd_dropped,
  output logic [NUM_RELAYS-1:0] coil_set,
  output logic [NUM_RELAYS-1:0] coil_reset
);

  localparam int CNT_MAX =
    max3(DEAD_CYCLES, PULSE_CYCLES, SETTLE_CYCLES);
  localparam int CNT_W =
    (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] DEAD_LD =
    CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PULSE_LD =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD =
    CNT_W'(SETTLE_CYCLES - 1);

  relay_state_t          state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  dir_q, dir_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  drop_q, drop_d;
  logic [NUM_RELAYS-1:0] set_q, set_d;
  logic [NUM_RELAYS-1:0] rst_q, rst_d;
  logic [NUM_RELAYS-1:0] sel;
  logic                  cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    ch_d    = ch_q;
    drop_d  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (relay_en) begin
          dir_d   = relay_dir;
          ch_d    = relay_channel;
          cnt_d   = DEAD_LD;
          state_d = ST_DEAD;
        end
      end
      ST_DEAD: begin
        drop_d = relay_en;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_zero) begin
          cnt_d   = PULSE_LD;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        drop_d = relay_en;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_zero) begin
          cnt_d   = SETTLE_LD;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        drop_d = relay_en;
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_zero) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Out-of-range channels match no bit, so no coil fires.
    sel = '0;
    for (int i = 0; i < NUM_RELAYS; i++) begin
      if (state_d == ST_PULSE && int'(ch_d) == i)
        sel[i] = 1'b1;
    end

    set_d  = dir_d ? sel : '0;
    rst_d  = dir_d ? '0 : sel;
    done_d = (state_d == ST_DONE);
    busy_d = (state_d == ST_DEAD) ||
             (state_d == ST_PULSE) ||
             (state_d == ST_SETTLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      ch_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      drop_q  <= 1'b0;
      set_q   <= '0;
      rst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      ch_q    <= ch_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      drop_q  <= drop_d;
      set_q   <= set_d;
      rst_q   <= rst_d;
    end
  end

  assign relay_done  = done_q;
  assign relay_busy  = busy_q;
  assign cmd_dropped = drop_q;
  assign coil_set    = set_q;
  assign coil_reset  = rst_q;

endmodule

// File: tb/tb_relay_pulse_controller.sv
// Directed and random checks of the relay sequencer
// with DEAD=2, PULSE=10, SETTLE=5.
module tb_relay_pulse_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       relay_en = 1'b0;
  logic       relay_dir = 1'b0;
  logic [1:0] relay_channel = 2'd0;
  logic       relay_done;
  logic       relay_busy;
  logic       cmd_dropped;
  logic [3:0] coil_set;
  logic [3:0] coil_reset;

  int total = 0;
  int bad = 0;

  relay_pulse_controller #(
    .NUM_RELAYS   (4),
    .DEAD_CYCLES  (2),
    .PULSE_CYCLES (10),
    .SETTLE_CYCLES(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .relay_en     (relay_en),
    .relay_dir    (relay_dir),
    .relay_channel(relay_channel),
    .relay_done   (relay_done),
    .relay_busy   (relay_busy),
    .cmd_dropped  (cmd_dropped),
    .coil_set     (coil_set),
    .coil_reset   (coil_reset)
  );

  always #5 clk = ~clk;

  wire [10:0] obs = {relay_busy, relay_done, cmd_dropped,
                     coil_set, coil_reset};

  // Expected outputs k cycles after the accepting edge E0.
  function automatic logic [10:0] exp_vec(
    int k, logic dir, int ch, logic drop);
    logic [3:0] c;
    logic [3:0] one;
    one = 4'b0001;
    c = (k >= 2 && k < 12) ? (one << ch) : 4'b0000;
    return {(k < 17), (k == 17), drop,
            dir ? c : 4'b0000, dir ? 4'b0000 : c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL reset_vals got=%b exp=%b", obs, 11'd0);
    end
    rst = 1'b0;
    tick();
    total++;
    if (obs !== 11'd0) begin
      bad++;
      $display("FAIL idle_after_rst got=%b exp=%b", obs, 11'd0);
    end
  endtask

  task automatic test_set_pulse();
    relay_en = 1'b1; relay_dir = 1'b1; relay_channel = 2'd2;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b1, 2, 1'b0)) begin
        bad++;
        $display("FAIL set_ch2 k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b1, 2, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_reset_pulse();
    relay_en = 1'b1; relay_dir = 1'b0; relay_channel = 2'd3;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b0, 3, 1'b0)) begin
        bad++;
        $display("FAIL reset_ch3 k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b0, 3, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_dropped();
    relay_en = 1'b1; relay_dir = 1'b1; relay_channel = 2'd1;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b1, 1, k == 5)) begin
        bad++;
        $display("FAIL dropped k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b1, 1, k == 5));
      end
      relay_en = (k == 4);
      relay_dir = 1'b1;
      relay_channel = (k == 4) ? 2'd0 : 2'd1;
      tick();
      relay_en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    relay_en = 1'b1; relay_dir = 1'b0; relay_channel = 2'd1;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 18; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b0, 1, 1'b0)) begin
        bad++;
        $display("FAIL b2b_first k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b0, 1, 1'b0));
      end
      if (k == 17) begin
        relay_en = 1'b1; relay_dir = 1'b1; relay_channel = 2'd3;
      end
      tick();
      relay_en = 1'b0;
    end
    for (int k = 0; k < 19; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b1, 3, 1'b0)) begin
        bad++;
        $display("FAIL b2b_second k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b1, 3, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_abort();
    relay_en = 1'b1; relay_dir = 1'b1; relay_channel = 2'd2;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b1, 2, 1'b0)) begin
        bad++;
        $display("FAIL abort_pre k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b1, 2, 1'b0));
      end
      rst = (k == 7);
      tick();
    end
    rst = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== 11'd0) begin
        bad++;
        $display("FAIL abort_quiet k=%0d got=%b exp=%b",
                 k, obs, 11'd0);
      end
      tick();
    end
    relay_en = 1'b1; relay_dir = 1'b0; relay_channel = 2'd0;
    tick();
    relay_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      total++;
      if (obs !== exp_vec(k, 1'b0, 0, 1'b0)) begin
        bad++;
        $display("FAIL abort_after k=%0d got=%b exp=%b",
                 k, obs, exp_vec(k, 1'b0, 0, 1'b0));
      end
      tick();
    end
  endtask

  task automatic test_random();
    int m_cnt = -1;
    int accepted = 0;
    int aborts = 0;
    int dones = 0;
    logic en_s, rst_s, exp_drop;
    for (int c = 0; c < 10000; c++) begin
      en_s  = (c < 9970) && ($urandom_range(7) == 0);
      rst_s = (c < 9970) && ($urandom_range(499) == 0);
      relay_en = en_s;
      rst = rst_s;
      relay_dir = 1'($urandom_range(1));
      relay_channel = 2'($urandom_range(3));
      tick();
      exp_drop = 1'b0;
      if (rst_s) begin
        if (m_cnt >= 0 && m_cnt < 17) aborts++;
        m_cnt = -1;
      end else if ((m_cnt < 0 || m_cnt == 17) && en_s) begin
        accepted++;
        m_cnt = 0;
      end else if (m_cnt >= 0) begin
        exp_drop = en_s && (m_cnt < 17);
        m_cnt++;
        if (m_cnt > 17) m_cnt = -1;
      end
      if (relay_done === 1'b1) dones++;
      total++;
      if ((coil_set & coil_reset) !== 4'd0 ||
          $countones(coil_set | coil_reset) > 1) begin
        bad++;
        $display("FAIL invariant c=%0d set=%b reset=%b",
                 c, coil_set, coil_reset);
      end
      total++;
      if ({relay_busy, relay_done, cmd_dropped} !==
          {(m_cnt >= 0 && m_cnt < 17), (m_cnt == 17),
           exp_drop}) begin
        bad++;
        $display("FAIL rand_ctl c=%0d got=%b%b%b m=%0d",
                 c, relay_busy, relay_done, cmd_dropped, m_cnt);
      end
    end
    relay_en = 1'b0;
    rst = 1'b0;
    total++;
    if (dones !== accepted - aborts) begin
      bad++;
      $display("FAIL done_count got=%0d exp=%0d",
               dones, accepted - aborts);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_set_pulse();
    test_reset_pulse();
    test_dropped();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
